// File: rtl/rs_pkg.sv
// RS(7,3) over GF(2^3): shared types, constants and the
// constant-multiplier helper used by encoder and decoder.
package rs_pkg;

  localparam int M = 3;
  localparam int N = 7;
  localparam int K = 3;

  localparam logic [M:0] PRIM = 4'b1011;

  typedef logic [M-1:0]   sym_t;
  typedef logic [N*M-1:0] cw_t;

  localparam sym_t G0 = 3'd3;
  localparam sym_t G1 = 3'd2;
  localparam sym_t G2 = 3'd1;
  localparam sym_t G3 = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Shift-and-add; with a constant k this folds to XOR gates.
  function automatic sym_t gf8_mul_const(
    input sym_t a,
    input sym_t k
  );
    sym_t acc;
    sym_t t;
    acc = '0;
    t   = a;
    for (int i = 0; i < M; i++) begin
      if (k[i]) acc = acc ^ t;
      t = {t[M-2:0], 1'b0} ^ ({M{t[M-1]}} & PRIM[M-1:0]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_parity_lfsr.sv
// Four-stage parity LFSR dividing x^4 m(x) by g(x),
// one symbol per shift, highest degree first.
module rs_parity_lfsr
  import rs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       shift_i,
  input  sym_t       sym_i,
  output sym_t [3:0] par_nxt_o
);

  sym_t [3:0] p_q;
  sym_t [3:0] shf;
  sym_t       fb;

  always_comb begin
    fb     = sym_i ^ p_q[3];
    shf[3] = p_q[2] ^ gf8_mul_const(fb, G3);
    shf[2] = p_q[1] ^ gf8_mul_const(fb, G2);
    shf[1] = p_q[0] ^ gf8_mul_const(fb, G1);
    shf[0] = gf8_mul_const(fb, G0);
  end

  assign par_nxt_o = shf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        p_q <= '0;
      end else if (shift_i) begin
        p_q <= shf;
      end
    end
  end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,3) encoder: accepts a 3-symbol message,
// emits {parity, message} in the decoder's packing.
module rs_encoder
  import rs_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*M-1:0] message,
  output logic           out_valid,
  input  logic           out_ready,
  output cw_t            codeword
);

  state_t         state_q;
  logic [K*M-1:0] msg_q;
  logic [1:0]     cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  cw_t            cw_q;

  sym_t       sym;
  sym_t [3:0] par_nxt;
  logic       clr;
  logic       shf;

  always_comb begin
    unique case (cnt_q)
      2'd0:    sym = msg_q[2:0];
      2'd1:    sym = msg_q[5:3];
      default: sym = msg_q[8:6];
    endcase
  end

  assign clr = (state_q == IDLE) && in_valid;
  assign shf = (state_q == SHIFT);

  rs_parity_lfsr u_lfsr (
    .clk       (clk),
    .rst_n     (reset),
    .en_i      (enable),
    .clr_i     (clr),
    .shift_i   (shf),
    .sym_i     (sym),
    .par_nxt_o (par_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cw_q        <= '0;
    end else if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            msg_q      <= message;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 2'd1;
          // Final shift: capture the LFSR's next state directly.
          if (cnt_q == 2'd2) begin
            cw_q <= {par_nxt[0], par_nxt[1],
                     par_nxt[2], par_nxt[3], msg_q};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign codeword  = cw_q;

endmodule

// File: doc/rs_encoder.md
Name: rs_encoder

Overview:
- Systematic RS(7,3) encoder over GF(2^3), primitive polynomial x^3+x+1, alpha = 3'b010.
- Generator g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4) = x^4 + a^3x^3 + x^2 + a x + a^3, i.e. coefficients g3..g0 = 3,1,2,3.
- Takes a 9-bit message and computes the four parity symbols with a symbol-serial LFSR. Presents a 21-bit codeword in the packing the RS decoder consumes, so encoder output feeds decoder input directly in loopback benches.

Parameters:
- M, 3, symbol width in bits; only 3 supported.
- N, 7, codeword length in symbols; only 7 supported.
- K, 3, message length in symbols; only 3 supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  clock enable; when 0 all state holds.
- in_valid  input  1  message offered.
- in_ready  output  1  encoder can accept a message.
- message  input  9  {m0,m1,m2}, m0 in [8:6]; m(x) = m0 + m1 x + m2 x^2.
- out_valid  output  1  codeword available.
- out_ready  input  1  consumer takes codeword.
- codeword  output  21  {c0,c1,...,c6}, c0 in [20:18], c6 in [2:0].
  - c0..c3 are parity (remainder of x^4 m(x) mod g).
  - c4..c6 = m0..m2.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, codeword=0, LFSR=0, symbol counter=0.
  - Asserting reset mid-operation aborts the encode; no partial codeword is ever flagged valid.
- enable=0: no state, register or output changes. Handshakes only complete on edges with enable=1.
- FSM:
  - IDLE: in_ready=1. On in_valid & enable at an edge:
    - latch message;
    - clear LFSR p0..p3;
    - cnt=0;
    - go to SHIFT.
  - SHIFT: in_ready=0. Each enabled edge feeds one symbol, highest degree first: m2, then m1, then m0 (cnt 0,1,2).
    - fb = s ^ p3
    - p3 <= p2 ^ a^3*fb
    - p2 <= p1 ^ fb
    - p1 <= p0 ^ a*fb
    - p0 <= a^3*fb
    - GF multiplies are constant multipliers, purely combinational.
    - On the cnt=2 edge, load codeword = {p0',p1',p2',p3',m0,m1,m2} from next-state values and go to DONE.
  - DONE: out_valid=1; codeword held stable. On out_ready & enable, go to IDLE (out_valid=0, in_ready=1 from the next cycle). The codeword register keeps its last value after the handshake.
- Latency: acceptance edge E0, shift edges E1..E3. out_valid is high in the cycle after E3. Minimum throughput is one codeword per 5 cycles.
- Back-pressure: out_ready low holds DONE indefinitely. in_valid is ignored outside IDLE, so there is no overlap of a new input with a pending output.
- Width rules: all symbol arithmetic is 3-bit XOR; nothing widens, nothing carries.

Decomposition:
- Package rs_pkg holds:
  - M, N, K;
  - primitive polynomial 4'b1011;
  - generator coefficients G0..G3;
  - symbol typedef (3-bit);
  - codeword typedef (21-bit);
  - FSM state enum {IDLE, SHIFT, DONE};
  - function gf8_mul_const for the constant multipliers.
- Sub-module rs_parity_lfsr contains the 4-stage parity register with clear/shift inputs, driven by the rs_encoder FSM. The same package is shared with the decoder.

Test Plan:
- Reset then message 9'b000_000_000 -> out_valid 4 enabled cycles after acceptance; codeword 21'h000000.
- message 9'b001_111_100 (m=1,7,4) -> codeword 21'b100_001_010_111_001_111_100 (c = 4,1,2,7,1,7,4). The bench also checks c(a)=c(a^2)=c(a^3)=c(a^4)=0.
- message 9'b001_000_000 (m=1) -> codeword 21'b011_010_001_011_001_000_000 (c = 3,2,1,3,1,0,0).
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and message -> out_valid stays 1, codeword unchanged, in_ready stays 0. Release -> IDLE next cycle.
- Deassert enable for 3 cycles during SHIFT -> result identical to the uninterrupted run, delayed by exactly 3 cycles.
- Pulse reset low mid-SHIFT -> out_valid=0 and codeword=0 immediately (asynchronous). A subsequent message encodes correctly. Loopback: 50 random messages through the RS decoder with no errors -> decoded equals message.
